// File: rtl/tensor_core_sequencer.sv
// Sequencer between the CPU instruction stream and the tensor core: register bursts into A/B,
// operate, and result writeback. Optional WAIT timeout: TENSOR_CORE_SEQUENCER_TIMEOUT_EN.
module tensor_core_sequencer #(
  parameter int unsigned MATRIX_DIM     = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned REG_ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned E             = MATRIX_DIM * MATRIX_DIM,
  localparam int unsigned IW            = (E > 1) ? $clog2(E) : 1
) (
  input  logic                      clock_in,
  input  logic                      reset_in,
  input  logic                      instruction_valid,
  input  logic [31:0]               instruction,
  output logic                      instruction_ready,
  output logic                      busy,
  output logic                      error,
  output logic [REG_ADDR_WIDTH-1:0] rf_read_address,
  input  logic [DATA_WIDTH-1:0]     rf_read_data,
  output logic                      rf_write_enable,
  output logic [REG_ADDR_WIDTH-1:0] rf_write_address,
  output logic [DATA_WIDTH-1:0]     rf_write_data,
  output logic                      tc_load_enable,
  output logic                      tc_load_matrix_select,
  output logic [IW-1:0]             tc_load_index,
  output logic [DATA_WIDTH-1:0]     tc_load_data,
  output logic                      tc_start,
  input  logic                      tc_done,
  output logic [IW-1:0]             tc_result_index,
  input  logic [DATA_WIDTH-1:0]     tc_result_data
);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StWriteback} state_t;

  state_t                    r_state, w_state_next;
  logic [IW-1:0]             r_idx, w_idx_next;
  logic [REG_ADDR_WIDTH-1:0] r_base, w_base_next;
  logic                      r_sel, w_sel_next;
  logic [7:0]                r_len, w_len_next;
  logic                      r_error, w_error_next;
  logic                      w_accept, w_load_legal, w_load_last, w_wb_last;

`ifdef TENSOR_CORE_SEQUENCER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wait, w_wait_next;
`endif

  assign instruction_ready = (r_state == StIdle) && !reset_in;
  assign busy              = (r_state != StIdle);
  assign error             = r_error;
  assign w_accept          = instruction_valid && instruction_ready;
  assign w_load_legal      = (instruction[23:16] <= 8'd1) && (instruction[15:8] != 8'd0) &&
                             (32'(instruction[15:8]) <= E);
  assign w_load_last       = (8'(r_idx) == (r_len - 8'd1));
  assign w_wb_last         = (r_idx == IW'(E - 1));

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_base  <= '0;
      r_sel   <= 1'b0;
      r_len   <= '0;
      r_error <= 1'b0;
`ifdef TENSOR_CORE_SEQUENCER_TIMEOUT_EN
      r_wait  <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_base  <= w_base_next;
      r_sel   <= w_sel_next;
      r_len   <= w_len_next;
      r_error <= w_error_next;
`ifdef TENSOR_CORE_SEQUENCER_TIMEOUT_EN
      r_wait  <= w_wait_next;
`endif
    end
  end

  always_comb begin
    w_state_next          = r_state;
    w_idx_next            = r_idx;
    w_base_next           = r_base;
    w_sel_next            = r_sel;
    w_len_next            = r_len;
    w_error_next          = 1'b0;
`ifdef TENSOR_CORE_SEQUENCER_TIMEOUT_EN
    w_wait_next           = r_wait;
`endif
    rf_read_address       = '0;
    rf_write_enable       = 1'b0;
    rf_write_address      = '0;
    rf_write_data         = '0;
    tc_load_enable        = 1'b0;
    tc_load_matrix_select = 1'b0;
    tc_load_index         = '0;
    tc_load_data          = '0;
    tc_start              = 1'b0;
    tc_result_index       = '0;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_base_next = REG_ADDR_WIDTH'(instruction[31:24]);
          w_sel_next  = instruction[16];
          w_len_next  = instruction[15:8];
          w_idx_next  = '0;
          if (instruction[7:0] == 8'h06) begin
            if (w_load_legal) w_state_next = StLoad;
            else              w_error_next = 1'b1;
          end else if (instruction[7:0] == 8'h05) begin
            w_state_next = StStart;
          end
        end
      end
      StLoad: begin
        rf_read_address       = r_base + REG_ADDR_WIDTH'(r_idx);
        tc_load_enable        = 1'b1;
        tc_load_matrix_select = r_sel;
        tc_load_index         = r_idx;
        tc_load_data          = rf_read_data;
        if (w_load_last) w_state_next = StIdle;
        else             w_idx_next   = r_idx + 1'b1;
      end
      StStart: begin
        tc_start     = 1'b1;
        w_state_next = StWait;
`ifdef TENSOR_CORE_SEQUENCER_TIMEOUT_EN
        w_wait_next  = '0;
`endif
      end
      StWait: begin
        if (tc_done) begin
          w_state_next = StWriteback;
          w_idx_next   = '0;
`ifdef TENSOR_CORE_SEQUENCER_TIMEOUT_EN
        end else if (r_wait == TW'(TIMEOUT_CYCLES - 1)) begin
          w_state_next = StIdle;
          w_error_next = 1'b1;
        end else begin
          w_wait_next  = r_wait + 1'b1;
`endif
        end
      end
      StWriteback: begin
        tc_result_index  = r_idx;
        rf_write_enable  = 1'b1;
        rf_write_address = r_base + REG_ADDR_WIDTH'(r_idx);
        rf_write_data    = tc_result_data;
        if (w_wb_last) w_state_next = StIdle;
        else           w_idx_next   = r_idx + 1'b1;
      end
      default: w_state_next = StIdle;
    endcase
  end

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// Self-checking bench: directed scenarios plus randomized instruction mix, compared against
// per-instruction expectations derived from the sequencer's behavioural rules.
module tb_tensor_core_sequencer;

  localparam int E = 4;

  logic        clock_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        instruction_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic        instruction_ready, busy, error;
  logic [7:0]  rf_read_address, rf_read_data, rf_write_address, rf_write_data;
  logic        rf_write_enable, tc_load_enable, tc_load_matrix_select, tc_start;
  logic [1:0]  tc_load_index, tc_result_index;
  logic [7:0]  tc_load_data, tc_result_data;
  logic        tc_done = 1'b0;

  logic [7:0]  rf_mem [256];
  logic [7:0]  tc_res [E];

  assign rf_read_data   = rf_mem[rf_read_address];
  assign tc_result_data = tc_res[tc_result_index];

  tensor_core_sequencer #(
    .MATRIX_DIM(2), .DATA_WIDTH(8), .REG_ADDR_WIDTH(8), .TIMEOUT_CYCLES(10)
  ) dut (
    .clock_in(clock_in), .reset_in(reset_in),
    .instruction_valid(instruction_valid), .instruction(instruction),
    .instruction_ready(instruction_ready), .busy(busy), .error(error),
    .rf_read_address(rf_read_address), .rf_read_data(rf_read_data),
    .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
    .rf_write_data(rf_write_data), .tc_load_enable(tc_load_enable),
    .tc_load_matrix_select(tc_load_matrix_select), .tc_load_index(tc_load_index),
    .tc_load_data(tc_load_data), .tc_start(tc_start), .tc_done(tc_done),
    .tc_result_index(tc_result_index), .tc_result_data(tc_result_data)
  );

  always #5 clock_in = ~clock_in;

  // Event log filled on falling edges; the main sequence reads it by snapshot deltas.
  logic [31:0] ld_addr [4096], ld_idx [4096], ld_sel [4096], ld_data [4096];
  logic [31:0] wr_addr [4096], wr_data [4096];
  int n_ld = 0, n_wr = 0, n_busy = 0, n_err = 0, n_start = 0, n_bad = 0;

  always @(negedge clock_in) begin
    if (tc_load_enable && n_ld < 4096) begin
      ld_addr[n_ld] <= 32'(rf_read_address);
      ld_idx[n_ld]  <= 32'(tc_load_index);
      ld_sel[n_ld]  <= 32'(tc_load_matrix_select);
      ld_data[n_ld] <= 32'(tc_load_data);
      n_ld          <= n_ld + 1;
    end
    if (rf_write_enable && n_wr < 4096) begin
      wr_addr[n_wr] <= 32'(rf_write_address);
      wr_data[n_wr] <= 32'(rf_write_data);
      n_wr          <= n_wr + 1;
    end
    if (busy)    n_busy  <= n_busy + 1;
    if (error)   n_err   <= n_err + 1;
    if (tc_start) n_start <= n_start + 1;
    if ((busy && instruction_ready) ||
        (!busy && (tc_load_enable || rf_write_enable || tc_start || tc_load_matrix_select ||
                   rf_read_address != 0 || rf_write_address != 0 || rf_write_data != 0 ||
                   tc_load_data != 0 || tc_load_index != 0 || tc_result_index != 0)))
      n_bad <= n_bad + 1;
  end

  int checks = 0;
  int errors = 0;
  int s_ld, s_wr, s_busy, s_err, s_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_ld = n_ld; s_wr = n_wr; s_busy = n_busy; s_err = n_err; s_start = n_start;
  endtask

  task automatic send(input logic [31:0] ins);
    @(posedge clock_in); #1;
    chk("ready_before_issue", 32'(instruction_ready), 1);
    instruction_valid = 1'b1;
    instruction       = ins;
    @(posedge clock_in); #1;
    instruction_valid = 1'b0;
    instruction       = $urandom;
  endtask

  // Waits for IDLE, checks ready there, then lets that cycle's falling edge be logged.
  task automatic finish_op(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clock_in); #1;
      n++;
    end
    chk("idle_reached", 32'(busy), 0);
    chk("ready_after_seq", 32'(instruction_ready), 1);
    @(negedge clock_in); #1;
  endtask

  task automatic do_load(input logic [7:0] base, input logic [7:0] bf, input logic [7:0] cf,
                         input bit randomize_regs);
    logic [7:0] exp_d [E];
    bit legal;
    legal = (bf <= 1) && (cf >= 1) && (cf <= E);
    for (int k = 0; k < E; k++) begin
      if (randomize_regs) rf_mem[8'(base + 8'(k))] = 8'($urandom);
      exp_d[k] = rf_mem[8'(base + 8'(k))];
    end
    snap();
    send({base, bf, cf, 8'h06});
    finish_op(20);
    chk("load_count", 32'(n_ld - s_ld), legal ? 32'(cf) : 0);
    chk("load_busy", 32'(n_busy - s_busy), legal ? 32'(cf) : 0);
    chk("load_error", 32'(n_err - s_err), legal ? 0 : 1);
    if (legal && n_ld - s_ld == int'(cf)) begin
      for (int k = 0; k < int'(cf); k++) begin
        chk($sformatf("ld_addr%0d", k), ld_addr[s_ld + k], 32'((int'(base) + k) % 256));
        chk($sformatf("ld_idx%0d", k), ld_idx[s_ld + k], 32'(k));
        chk($sformatf("ld_sel%0d", k), ld_sel[s_ld + k], 32'(bf[0]));
        chk($sformatf("ld_data%0d", k), ld_data[s_ld + k], 32'(exp_d[k]));
      end
    end
  endtask

  task automatic do_other(input logic [31:0] ins);
    snap();
    send(ins);
    finish_op(4);
    chk("other_busy", 32'(n_busy - s_busy), 0);
    chk("other_error", 32'(n_err - s_err), 0);
    chk("other_events", 32'((n_ld - s_ld) + (n_wr - s_wr) + (n_start - s_start)), 0);
  endtask

  // tc_done goes high for one cycle exactly d cycles after the tc_start cycle.
  task automatic do_op(input logic [7:0] base, input int d, input bit early_done,
                       input bit randomize_res);
    if (randomize_res) for (int k = 0; k < E; k++) tc_res[k] = 8'($urandom);
    snap();
    send({base, 8'($urandom), 8'($urandom), 8'h05});
    chk("op_start_pulse", 32'(tc_start), 1);
    tc_done = early_done;
    @(posedge clock_in); #1;
    tc_done = 1'b0;
    repeat (d - 1) begin
      @(posedge clock_in); #1;
    end
    tc_done = 1'b1;
    @(posedge clock_in); #1;
    tc_done = 1'b0;
    finish_op(20);
    chk("op_starts", 32'(n_start - s_start), 1);
    chk("op_busy", 32'(n_busy - s_busy), 32'(1 + d + E));
    chk("op_error", 32'(n_err - s_err), 0);
    chk("op_writes", 32'(n_wr - s_wr), E);
    if (n_wr - s_wr == E) begin
      for (int k = 0; k < E; k++) begin
        chk($sformatf("wr_addr%0d", k), wr_addr[s_wr + k], 32'((int'(base) + k) % 256));
        chk($sformatf("wr_data%0d", k), wr_data[s_wr + k], 32'(tc_res[k]));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rf_mem[i] = 8'($urandom);
    for (int k = 0; k < E; k++) tc_res[k] = '0;
    #3;
    chk("rst_ready", 32'(instruction_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_strobes", 32'({tc_load_enable, rf_write_enable, tc_start}), 0);
    @(posedge clock_in); #1;
    @(posedge clock_in); #1;
    reset_in = 1'b0;
    #1;
    chk("post_rst_ready", 32'(instruction_ready), 1);

    // Directed: burst into A from 40..43
    rf_mem[40] = 1; rf_mem[41] = 2; rf_mem[42] = 3; rf_mem[43] = 4;
    do_load(8'd40, 8'd0, 8'd4, 1'b0);
    do_load(8'd40, 8'd0, 8'd0, 1'b0);
    do_load(8'd40, 8'd0, 8'd5, 1'b0);
    do_load(8'd40, 8'd2, 8'd4, 1'b0);
    do_other(32'h05010A09);
    // Address wrap into B
    rf_mem[254] = 9; rf_mem[255] = 8; rf_mem[0] = 7; rf_mem[1] = 6;
    do_load(8'd254, 8'd1, 8'd4, 1'b0);
    tc_res[0] = 19; tc_res[1] = 22; tc_res[2] = 43; tc_res[3] = 50;
    do_op(8'd100, 6, 1'b0, 1'b0);

    // Reset while in WAIT: immediate quiet outputs, nothing written
    snap();
    send(32'h64000005);
    @(posedge clock_in); #1;
    @(posedge clock_in); #1;
    reset_in = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(instruction_ready), 0);
    chk("midrst_strobes", 32'({tc_load_enable, rf_write_enable, tc_start, error}), 0);
    @(posedge clock_in); #1;
    reset_in = 1'b0;
    repeat (8) @(posedge clock_in);
    #1;
    chk("midrst_writes", 32'(n_wr - s_wr), 0);
    do_op(8'd100, 6, 1'b0, 1'b0);

    // A done coincident with tc_start must not shortcut WAIT
    do_op(8'd7, 3, 1'b1, 1'b1);

`ifdef TENSOR_CORE_SEQUENCER_TIMEOUT_EN
    snap();
    send(32'h30000005);
    finish_op(40);
    chk("to_busy", 32'(n_busy - s_busy), 11);
    chk("to_error", 32'(n_err - s_err), 1);
    chk("to_writes", 32'(n_wr - s_wr), 0);
`else
    do_op(8'd200, 300, 1'b0, 1'b1);
`endif

    // Randomized mix
    for (int it = 0; it < 40; it++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r <= 4)
        do_load(8'($urandom), 8'($urandom_range(0, 1)), 8'($urandom_range(1, E)), 1'b1);
      else if (r == 5)
        do_load(8'($urandom), 8'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(E + 1, 255)), 1'b1);
      else if (r == 6)
        do_load(8'($urandom), 8'($urandom_range(2, 255)), 8'($urandom_range(1, E)), 1'b1);
      else if (r == 7)
        do_other({24'($urandom), 8'($urandom_range(7, 255))});
      else
        do_op(8'($urandom), int'($urandom_range(1, 10)), 1'($urandom), 1'b1);
    end

    chk("protocol_violations", 32'(n_bad), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
